// File: rtl/io_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_rx
// Purpose  : Memory-mapped UART receiver (8N1). Deserialises frames from the
//            rxd pin, queues received bytes in a small circular FIFO and
//            returns them through a single read-to-pop IO register.
// Ports    : clk       - system clock, all state changes on rising edge
//            reset_n   - asynchronous active-low reset
//            rxd       - serial line, asynchronous to clk, idles high
//            rd_strb   - one-cycle read strobe from the IO address decode
//            rdata     - registered read data
//                        [7:0] byte, [8] valid, [9] overrun, [10] frame_err
//            rx_avail  - high while the FIFO holds at least one byte
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_rx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd,
  input  logic        rd_strb,
  output logic [31:0] rdata,
  output logic        rx_avail
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  // Half a bit minus one: the start bit is sampled at its centre, and every
  // later sample is one full bit period after the previous one.
  localparam logic [CNT_W-1:0]  CNT_HALF   = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_FW-1:0] FIFO_FULL  = CNT_FW'(FIFO_DEPTH);
  localparam logic [CNT_FW-1:0] FIFO_ONE   = CNT_FW'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser (both flops reset to the idle level)
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitidx;
  logic [7:0]       shreg;

  logic sample;
  logic push;
  logic frame_ev;

  assign sample   = (cnt == '0);
  // Stop-bit outcome, evaluated on the same edge the FSM leaves STOP.
  assign push     = (state == ST_STOP) && sample && rx_s;
  assign frame_ev = (state == ST_STOP) && sample && !rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= CNT_HALF;
          end
        end

        ST_START: begin
          if (!sample) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt <= CNT_RELOAD;
            if (rx_s) begin
              // Line back high at the start-bit centre: a glitch, not a frame.
              state <= ST_IDLE;
            end else begin
              bitidx <= '0;
              state  <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (!sample) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt    <= CNT_RELOAD;
            shreg  <= {rx_s, shreg[7:1]};
            bitidx <= bitidx + 3'd1;
            if (bitidx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end

        ST_STOP: begin
          if (!sample) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt <= CNT_RELOAD;
            // Returning to IDLE right at the stop-bit centre lets a following
            // start bit be caught with no gap.
            state <= rx_s ? ST_IDLE : ST_BREAK;
          end
        end

        ST_BREAK: begin
          // Held-low line: wait for it to go idle so a break reports one
          // framing error rather than a stream of zero frames.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count;

  logic nonempty;
  logic full;
  logic pop;
  logic do_push;

  assign nonempty = (count != '0);
  assign full     = (count == FIFO_FULL);
  assign pop      = rd_strb && nonempty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, pop})
        2'b10:   count <= count + FIFO_ONE;
        2'b01:   count <= count - FIFO_ONE;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status flags and read register
  // --------------------------------------------------------------------------
  logic overrun;
  logic frame_err;
  logic overrun_ev;

  assign overrun_ev = push && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rdata     <= '0;
    end else begin
      // An event on the read edge takes priority so it is not lost.
      if (overrun_ev) begin
        overrun <= 1'b1;
      end else if (rd_strb) begin
        overrun <= 1'b0;
      end

      if (frame_ev) begin
        frame_err <= 1'b1;
      end else if (rd_strb) begin
        frame_err <= 1'b0;
      end

      if (rd_strb) begin
        rdata <= {21'b0, frame_err, overrun, nonempty,
                  nonempty ? mem[rd_ptr] : 8'h00};
      end
    end
  end

  assign rx_avail = nonempty;

endmodule
`default_nettype wire

// File: doc/io_uart_rx.md
# io_uart_rx

Memory-mapped UART receiver for the SOC IO page, the input-side counterpart of the UART transmitter. It deserialises 8N1 frames from the RXD pin, buffers received bytes in a small FIFO, and returns them to the processor through a single read-to-pop IO register. The SOC decodes the address (IO page, one-hot word-address bit `IO_UART_RX_bit` = 3, byte offset 0x20) and ORs `rdata` into the IO read mux.

## Interface
- `CLK_FREQ_HZ`, 10_000_000: system clock frequency.
- `BAUD_RATE`, 1_000_000: line rate. `DIV = CLK_FREQ_HZ/BAUD_RATE` (integer); `DIV >= 4` is required.
- `FIFO_DEPTH`, 4: FIFO entries. Must be a power of 2, at least 2.
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: UART line, asynchronous to `clk`. Idles high.
- `rd_strb` in 1: one-cycle read strobe, equal to `isIO & mem_rstrb & mem_wordaddr[3]`.
- `rdata` out 32: registered read data.
  - [7:0] data byte
  - [8] valid
  - [9] overrun
  - [10] frame_err
  - [31:11] always 0
- `rx_avail` out 1: high while the FIFO is non-empty.

## Operation
- Synchroniser: 2-flop on `rxd`, both flops reset to 1. `rx_s` is the second flop. The FSM uses only `rx_s`.
- Bit counter `cnt`, width clog2(DIV). In START, DATA and STOP, each edge:
  - if `cnt != 0`: decrement;
  - if `cnt == 0`: perform the state's sample action and reload `DIV-1`.
- FSM states (reset state IDLE):
  - **IDLE**: when `rx_s == 0`, go to START and set `cnt = DIV/2 - 1`.
  - **START**, at sample: if `rx_s == 1`, this is a false start; go to IDLE with nothing recorded. Otherwise set `bitidx = 0` and go to DATA.
  - **DATA**, at sample: shift `rx_s` in LSB-first (`shreg <= {rx_s, shreg[7:1]}`). After bit 7, go to STOP.
  - **STOP**, at sample:
    - if `rx_s == 1`: push `shreg` into the FIFO (see overrun below) and go to IDLE;
    - if `rx_s == 0`: discard the byte, set sticky `frame_err`, and go to BREAK.
  - **BREAK**: wait for `rx_s == 1`, then go to IDLE. A held-low line therefore yields exactly one frame error, not repeated frames.
- FIFO: circular buffer with wrapping read/write pointers and a count register of width clog2(FIFO_DEPTH)+1.
- Read (`rd_strb == 1`) loads `rdata` on the same edge:
  - FIFO non-empty: `{21'b0, frame_err, overrun, 1'b1, head}`, then pop.
  - FIFO empty: `{21'b0, frame_err, overrun, 9'b0}`.
  - Both sticky flags clear on any read. A flag event on the same edge as the read wins: the flag stays set for the next read.
- `rdata` holds its value while `rd_strb == 0`.
- Overrun: a push while the FIFO is full and not popping on the same edge drops the new byte, sets sticky `overrun`, and leaves the FIFO contents unchanged.
- Simultaneous push and pop:
  - FIFO full: the pop frees a slot, the push is accepted, and `overrun` is not set.
  - FIFO empty: the read returns valid = 0 and the pushed byte is stored (count becomes 1).
- Reset mid-frame: the frame is abandoned. FIFO, flags and FSM are cleared; after release the FSM waits in IDLE for the next falling edge.

## Timing
- Reset values:
  - `rdata` = 0, `rx_avail` = 0;
  - sync flops = 1, FSM = IDLE, `cnt` = 0;
  - FIFO pointers and count = 0;
  - `overrun` = 0, `frame_err` = 0.
- Edge numbering: edge 0 is the first rising edge at which `rxd` is sampled low.
  - `rx_s` is low after edge 1.
  - FSM enters START at edge 2.
  - Start bit is sampled at edge 2+DIV/2.
  - Data bit k is sampled at edge 2+DIV/2+(k+1)·DIV.
  - Stop bit is sampled, and the byte pushed, at edge 2+DIV/2+9·DIV (97 for DIV = 10).
  - `rx_avail` rises after that edge.
- Read latency: `rdata` is valid the cycle after `rd_strb`. This matches the processor latching `mem_rdata` in WAIT_DATA, one cycle after the LOAD strobe.
- `rx_avail` falls on the edge that pops the last entry.
- Back-to-back frames: the next start bit's falling edge may arrive immediately after the stop-bit centre with no loss.
- Sampling tolerance: sampling occurs at bit centre ±1 clk. Sender/receiver rate mismatch up to ±3% must receive correctly at DIV = 10.

## Test plan
- Reset, then send 0x55 and 0xA3 at DIV = 10 → `rx_avail` rises after edge 97 of the first frame. Two reads return 0x155 then 0x1A3. A third read returns 0x000 and `rx_avail` = 0.
- Low glitch of 3 clks on `rxd` → START sample sees 1 and the FSM returns to IDLE. FIFO is empty, flags are 0, and a read returns 0x000.
- 5 frames (0x01..0x05) with no reads at FIFO_DEPTH = 4 → reads return 0x301, 0x102, 0x103, 0x104, then 0x000. The 5th byte is dropped; `overrun` is reported once, then cleared.
- Frame 0x7E with stop bit 0, `rxd` held low for 30 bit times, then valid frame 0x42 → exactly one `frame_err`. Reads return 0x542 then 0x000 (`frame_err` on the 0x42 read, then cleared).
- FIFO full, `rd_strb` asserted on the edge the 5th byte is pushed → pop accepted and push stored. `overrun` remains 0. Four subsequent reads drain entries 2..5 in order.
- `reset_n` pulsed low during data bit 4 of a frame → all outputs are 0 immediately, no byte is pushed, and the next complete frame 0xC3 reads back as 0x1C3.
